// File: rtl/vp_gfx_scheduler_pkg.sv
// Shared types for the graphics-cell fetch scheduler: FSM states and the
// video-memory cell word layout ([31:28] fg, [27:24] bg, [23] mosaic, [19:0] gfx).
package vp_gfx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [3:0]  fg;
        logic [3:0]  bg;
        logic        mosaic;
        logic [2:0]  rsvd;
        logic [19:0] gfx;
    } cell_word_t;

    // FIFO entry: the fetched word tagged with the scanline it was fetched for.
    typedef struct packed {
        cell_word_t  word;
        logic [4:0]  char_row;
    } cell_t;

    function automatic cell_t make_cell(input logic [31:0] w, input logic [4:0] row);
        cell_t c;
        c.word     = cell_word_t'(w);
        c.char_row = row;
        return c;
    endfunction

endpackage

// File: rtl/vp_gfx_cell_fifo.sv
// 2-entry cell FIFO; head is readable combinationally, push lands the next cycle.
// Push is refused only when full and not popping; flush wins over push and pop.
module vp_gfx_cell_fifo
    import vp_gfx_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  cell_t      push_dat,
    input  logic       pop,
    output cell_t      head_dat,
    output logic [1:0] count
);

    cell_t      mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset: count_q gates every read that matters.
    always_ff @(posedge clk) begin
        if (reset && !flush && do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/vp_gfx_scheduler.sv
// Per-scanline cell fetch scheduler: walks COLS cells of the text row, buffers them, hands
// them out one cycle after cell_ready. Optional VP_GFX_SCHED_STATS_EN adds underflow_count.
module vp_gfx_scheduler
    import vp_gfx_scheduler_pkg::*;
#(
    parameter int COLS        = 80,
    parameter int ROWS        = 51,
    parameter int CHAR_HEIGHT = 20,
    parameter int ADDR_WIDTH  = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  line_start,
    input  logic [ADDR_WIDTH-1:0] base_address,
    output logic                  mem_request,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_data,
    input  logic                  cell_ready,
    output logic [3:0]            foreground,
    output logic [3:0]            background,
    output logic [19:0]           gfx_bits,
    output logic                  mosaic,
    output logic [4:0]            char_row,
    output logic                  enabled,
    output logic                  busy,
    output logic                  underflow,
    output logic                  line_overrun
`ifdef VP_GFX_SCHED_STATS_EN
    ,
    output logic [15:0]           underflow_count
`endif
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS + 1) : 1;
    localparam int TR_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    sched_state_e          state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [4:0]            row_cnt_q, row_cnt_d;
    logic [TR_W-1:0]       text_row_q, text_row_d;
    logic                  discard_q, discard_d;
    logic                  underflow_q, underflow_d;
    logic                  overrun_q, overrun_d;
    cell_t                 cell_q;
    logic                  enabled_q;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [1:0]            fifo_count;
    cell_t                 fifo_head;
    cell_t                 fifo_in;
    logic                  uf_evt;
    logic                  rsvd_unused;

    assign fifo_in  = make_cell(mem_data, row_cnt_q);
    assign fifo_pop = cell_ready && (fifo_count != 2'd0) && !frame_start;
    assign uf_evt   = cell_ready && (fifo_count == 2'd0) && !frame_start;

    vp_gfx_cell_fifo u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (frame_start),
        .push     (fifo_push),
        .push_dat (fifo_in),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .count    (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cur_addr_d  = cur_addr_q;
        row_base_d  = row_base_q;
        base_d      = base_q;
        row_cnt_d   = row_cnt_q;
        text_row_d  = text_row_q;
        discard_d   = discard_q;
        underflow_d = underflow_q || uf_evt;
        overrun_d   = overrun_q;
        fifo_push   = 1'b0;

        if (frame_start) begin
            base_d      = base_address;
            row_base_d  = base_address;
            row_cnt_d   = '0;
            text_row_d  = '0;
            underflow_d = 1'b0;
            overrun_d   = 1'b0;
            // An outstanding read must still be acked; its data is dropped on arrival.
            if (state_q == ST_WAIT && !mem_ack) begin
                discard_d = 1'b1;
            end else begin
                discard_d = 1'b0;
                state_d   = ST_IDLE;
            end
        end else begin
            if (line_start && state_q != ST_IDLE) begin
                overrun_d = 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (line_start) begin
                        col_d      = '0;
                        cur_addr_d = row_base_q;
                        state_d    = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (fifo_count != 2'd2) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = ST_IDLE;
                        end else begin
                            fifo_push  = 1'b1;
                            cur_addr_d = cur_addr_q + 1'b1;
                            col_d      = col_q + 1'b1;
                            state_d    = (col_q == COL_W'(COLS - 1)) ? ST_DRAIN : ST_REQ;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_count == 2'd0) begin
                        state_d = ST_IDLE;
                        if (row_cnt_q == 5'(CHAR_HEIGHT - 1)) begin
                            row_cnt_d = '0;
                            if (text_row_q == TR_W'(ROWS - 1)) begin
                                text_row_d = '0;
                                row_base_d = base_q;
                            end else begin
                                text_row_d = text_row_q + 1'b1;
                                row_base_d = row_base_q + ADDR_WIDTH'(COLS);
                            end
                        end else begin
                            row_cnt_d = row_cnt_q + 5'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            cur_addr_q  <= '0;
            row_base_q  <= '0;
            base_q      <= '0;
            row_cnt_q   <= '0;
            text_row_q  <= '0;
            discard_q   <= 1'b0;
            underflow_q <= 1'b0;
            overrun_q   <= 1'b0;
            cell_q      <= '0;
            enabled_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            cur_addr_q  <= cur_addr_d;
            row_base_q  <= row_base_d;
            base_q      <= base_d;
            row_cnt_q   <= row_cnt_d;
            text_row_q  <= text_row_d;
            discard_q   <= discard_d;
            underflow_q <= underflow_d;
            overrun_q   <= overrun_d;
            enabled_q   <= fifo_pop;
            if (fifo_pop) begin
                cell_q <= fifo_head;
            end
        end
    end

`ifdef VP_GFX_SCHED_STATS_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (frame_start) begin
            ucnt_d = '0;
        end else if (uf_evt && ucnt_q != 16'hFFFF) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underflow_count = ucnt_q;
`endif

    assign rsvd_unused  = ^cell_q.word.rsvd;
    assign mem_request  = (state_q == ST_WAIT);
    assign mem_address  = cur_addr_q;
    assign busy         = (state_q != ST_IDLE);
    assign foreground   = cell_q.word.fg;
    assign background   = cell_q.word.bg;
    assign mosaic       = cell_q.word.mosaic;
    assign gfx_bits     = cell_q.word.gfx;
    assign char_row     = cell_q.char_row;
    assign enabled      = enabled_q;
    assign underflow    = underflow_q;
    assign line_overrun = overrun_q;

endmodule

// File: tb/tb_vp_gfx_scheduler.sv
// Bench for vp_gfx_scheduler: random memory latency and shifter demand against a
// queue-based model of the fetch order, FIFO contents and sticky flags.
`timescale 1ns/1ps
module tb_vp_gfx_scheduler;

    localparam int COLS = 80;
    localparam int ROWS = 3;
    localparam int CH   = 20;
    localparam int AW   = 23;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          frame_start = 1'b0;
    logic          line_start = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic          mem_request;
    logic [AW-1:0] mem_address;
    logic          mem_ack = 1'b0;
    logic [31:0]   mem_data = '0;
    logic          cell_ready = 1'b0;
    logic [3:0]    foreground;
    logic [3:0]    background;
    logic [19:0]   gfx_bits;
    logic          mosaic;
    logic [4:0]    char_row;
    logic          enabled;
    logic          busy;
    logic          underflow;
    logic          line_overrun;
`ifdef VP_GFX_SCHED_STATS_EN
    logic [15:0]   underflow_count;
`endif

    vp_gfx_scheduler #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_HEIGHT(CH), .ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .line_start   (line_start),
        .base_address (base_address),
        .mem_request  (mem_request),
        .mem_address  (mem_address),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .cell_ready   (cell_ready),
        .foreground   (foreground),
        .background   (background),
        .gfx_bits     (gfx_bits),
        .mosaic       (mosaic),
        .char_row     (char_row),
        .enabled      (enabled),
        .busy         (busy),
        .underflow    (underflow),
        .line_overrun (line_overrun)
`ifdef VP_GFX_SCHED_STATS_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    logic [33:0]   fifo_m [$];
    int            exp_line = 0;
    int            exp_col = 0;
    int            line_acks = 0;
    int            en_cnt = 0;
    int            lat_min = 2;
    int            lat_max = 2;
    int            wait_cnt = 0;
    bit            req_seen = 0;
    bit            discard = 0;
    bit            line_active = 0;
    bit            uf_m = 0;
    bit            ov_m = 0;
    logic [15:0]   ucnt_m = '0;
    logic [AW-1:0] base_m = '0;
    logic [AW-1:0] cur_exp = '0;
    logic [AW-1:0] first_addr [0:127];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mix(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h0F0F5A5A;
    endfunction

    // Cell (line, col) lives at base + text_row*COLS + col, text rows recycling every ROWS.
    function automatic logic [AW-1:0] addr_of(input int line, input int col);
        return base_m + AW'(((line / CH) % ROWS) * COLS + col);
    endfunction

    function automatic bit crp(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic cyc(input bit fs, input bit ls, input bit cr);
        bit          ack;
        bit          pop;
        logic [33:0] popped;
        logic [31:0] d;
        ack    = 1'b0;
        pop    = 1'b0;
        popped = '0;
        if (mem_request && !req_seen) begin
            req_seen = 1'b1;
            wait_cnt = int'($urandom_range(lat_max, lat_min));
            cur_exp  = addr_of(exp_line, exp_col);
            chk("req_addr", mem_address, cur_exp);
            chk("req_room", fifo_m.size() < 2, 1);
            if (exp_col == 0 && exp_line < 128) first_addr[exp_line] = mem_address;
        end
        if (mem_request && req_seen) begin
            if (wait_cnt == 0) ack = 1'b1;
            else wait_cnt--;
        end
        mem_ack     = ack;
        mem_data    = ack ? mix(mem_address) : $urandom();
        frame_start = fs;
        line_start  = ls;
        cell_ready  = cr;

        if (fs) begin
            discard = mem_request && !ack;
            if (ack) req_seen = 1'b0;
            fifo_m.delete();
            base_m      = base_address;
            exp_line    = 0;
            exp_col     = 0;
            uf_m        = 1'b0;
            ov_m        = 1'b0;
            ucnt_m      = '0;
            line_active = 1'b0;
        end else begin
            if (cr && fifo_m.size() > 0) begin
                pop    = 1'b1;
                popped = fifo_m.pop_front();
            end else if (cr) begin
                uf_m = 1'b1;
                if (ucnt_m != 16'hFFFF) ucnt_m++;
            end
            if (ls) begin
                if (line_active) ov_m = 1'b1;
                else line_active = 1'b1;
            end
            if (ack) begin
                req_seen = 1'b0;
                if (discard) begin
                    discard = 1'b0;
                end else begin
                    d = mix(cur_exp);
                    fifo_m.push_back({d[31:23], d[19:0], 5'(exp_line % CH)});
                    line_acks++;
                    exp_col++;
                    if (exp_col == COLS) begin
                        exp_col = 0;
                        exp_line++;
                    end
                end
            end
        end

        @(posedge clk);
        #1;
        frame_start = 1'b0;
        line_start  = 1'b0;
        mem_ack     = 1'b0;
        if (enabled) en_cnt++;
        chk("enabled", enabled, pop);
        if (pop) chk("cell", {foreground, background, mosaic, gfx_bits, char_row}, popped);
        chk("underflow", underflow, uf_m);
        chk("overrun", line_overrun, ov_m);
`ifdef VP_GFX_SCHED_STATS_EN
        chk("uf_count", underflow_count, ucnt_m);
`endif
    endtask

    task automatic finish_line(input int mode, input string tag);
        int n;
        n = 0;
        while (!(busy == 1'b0 && fifo_m.size() == 0 && exp_col == 0 && !req_seen) && n < 3000) begin
            cyc(1'b0, 1'b0, crp(mode));
            n++;
        end
        chk({tag, "_done"}, n < 3000, 1);
        line_active = 1'b0;
    endtask

    task automatic new_line(input int mode);
        line_acks = 0;
        cyc(1'b0, 1'b1, crp(mode));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", mem_request, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", enabled, 0);
        chk("rst_uf", underflow, 0);
        chk("rst_ov", line_overrun, 0);
        chk("rst_cell", {foreground, background, mosaic, gfx_bits, char_row}, 0);
        reset = 1'b1;

        base_address = 23'h100;
        cyc(1'b1, 1'b0, 1'b0);

        // First line: fixed 2-cycle latency, shifter always ready.
        en_cnt = 0;
        new_line(1);
        finish_line(1, "line0");
        chk("line0_pulses", en_cnt, COLS);
        chk("line0_busy", busy, 0);

        // Shifter stalled: the FIFO fills after two reads and fetching pauses.
        new_line(0);
        repeat (40) cyc(1'b0, 1'b0, 1'b0);
        chk("hold_acks", line_acks, 2);
        chk("hold_req", mem_request, 0);
        finish_line(1, "hold");

        // Rest of the frame and the start of the next, random latency and demand.
        lat_min = 0;
        lat_max = 3;
        for (int k = 0; k < ROWS * CH; k++) begin
            new_line(2);
            finish_line(2, "rand");
        end
        chk("row1_addr", first_addr[CH], 23'h150);
        chk("wrap_addr", first_addr[ROWS * CH], 23'h100);

        // Extra line_start mid-fetch.
        new_line(2);
        for (int k = 0; k < 2000 && line_acks < 5; k++) cyc(1'b0, 1'b0, crp(2));
        cyc(1'b0, 1'b1, crp(2));
        finish_line(2, "ovr");
        chk("ovr_flag", line_overrun, 1);
        chk("ovr_acks", line_acks, COLS);
        new_line(2);
        finish_line(2, "after_ovr");

        // frame_start while a read is outstanding.
        lat_min = 4;
        lat_max = 4;
        new_line(0);
        for (int k = 0; k < 200 && !req_seen; k++) cyc(1'b0, 1'b0, 1'b0);
        en_cnt = 0;
        base_address = 23'h100;
        cyc(1'b1, 1'b0, 1'b0);
        chk("fs_hold_req", mem_request, 1);
        finish_line(1, "fs_drop");
        chk("fs_no_en", en_cnt, 0);
        lat_min = 1;
        lat_max = 2;
        new_line(2);
        finish_line(2, "fs_restart");
        chk("fs_restart_addr", first_addr[0], 23'h100);

        // Base near the top of memory: addresses wrap modulo 2^AW.
        base_address = 23'h7FFFE0;
        cyc(1'b1, 1'b0, 1'b0);
        new_line(2);
        finish_line(2, "addr_wrap");
        chk("wrap_base", first_addr[0], 23'h7FFFE0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vp_gfx_scheduler.md
Name: vp_gfx_scheduler

Overview:
Fetch scheduler for the graphics-cell bitmap stage. For each displayed scanline it walks the COLS character cells of the current text row and reads each 32-bit cell word from video memory over a request/ack port. It buffers fetched cells in a 2-entry FIFO and presents them, with the current char_row, to the bitmap expansion stage when the pixel shifter asks for the next cell. It owns the char_row/text_row counters and the memory address sequencing.

Parameters:
COLS, 80, character cells per text row
ROWS, 51, text rows per frame
CHAR_HEIGHT, 20, scanlines per character row (char_row 0..CHAR_HEIGHT-1)
ADDR_WIDTH, 23, video memory word address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
frame_start  in  1  one-cycle pulse, start of frame
line_start  in  1  one-cycle pulse, start of visible scanline
base_address  in  ADDR_WIDTH  address of cell (0,0); sampled on frame_start
mem_request  out  1  read request, held until mem_ack
mem_address  out  ADDR_WIDTH  word address, stable while mem_request high
mem_ack  in  1  one-cycle ack; mem_data valid this cycle
mem_data  in  32  cell word: [31:28] fg, [27:24] bg, [23] mosaic, [22:20] reserved, [19:0] gfx bits
cell_ready  in  1  pixel shifter requests next cell
foreground  out  4  cell foreground
background  out  4  cell background
gfx_bits  out  20  cell gfx bits
mosaic  out  1  cell mosaic flag
char_row  out  5  current scanline within character row
enabled  out  1  one-cycle pulse: cell outputs valid
busy  out  1  line fetch in progress
underflow  out  1  sticky: cell_ready with FIFO empty
line_overrun  out  1  sticky: line_start while busy

Behaviour:
- Reset (reset=0 at clk edge): all outputs 0, state IDLE, char_row=0, text_row=0, row_base=0, FIFO empty, sticky flags cleared.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: line_start -> col=0, cur_addr=row_base, busy=1, go REQ.
- REQ: if FIFO occupancy < 2, assert mem_request with mem_address=cur_addr, go WAIT; otherwise stay in REQ.
- WAIT: hold request and address. On mem_ack: drop mem_request the same edge, write mem_data into FIFO, cur_addr+1 (mod 2^ADDR_WIDTH), col+1. If col was COLS-1, go DRAIN; else REQ.
- DRAIN: wait for FIFO empty, then advance counters and return to IDLE with busy=0.
- Counter advance: char_row+1. At CHAR_HEIGHT-1, wrap to 0 and text_row+1, with row_base+=COLS. At text_row ROWS-1, text_row wraps to 0 and row_base=base_address.
- Output: cell_ready sampled with FIFO non-empty pops the head. foreground/background/gfx_bits/mosaic/char_row are registered, with enabled=1 on the next cycle (1-cycle latency), and enabled=0 otherwise. Outputs hold their last values when enabled=0.
- cell_ready with FIFO empty: no pop, enabled=0, underflow set (sticky).
- FIFO write and pop in the same cycle are both honoured; occupancy is unchanged.
- line_start while busy: ignored, line_overrun set (sticky).
- frame_start has priority over line_start. It flushes the FIFO, clears sticky flags, sets char_row=0, text_row=0, row_base=base_address.
  - If WAIT: keep mem_request until mem_ack, discard that data, then IDLE.
  - Otherwise go directly to IDLE.
- Reset mid-transaction drops mem_request immediately; the memory arbiter tolerates an abandoned request.

Optional Feature:
VP_GFX_SCHED_STATS_EN: adds output underflow_count (16 bits).
- Increments, saturating at 16'hFFFF, on every underflow event.
- Cleared by reset and frame_start.
- Without the macro the port and counter do not exist; underflow sticky behaviour is identical.

Decomposition:
- Cell word field positions and the state encodings go in the shared constant.v include.
- One sub-module: vp_gfx_cell_fifo.
  - 2-entry, 37-bit (fg, bg, mosaic, gfx, char_row) synchronous FIFO.
  - Has push/pop/flush and count outputs.

Test Plan:
- Reset, then frame_start with base_address=0x100, line_start, mem_ack 2 cycles after each request, cell_ready always 1 -> addresses 0x100..0x14F, 80 enabled pulses with char_row=0, busy falls after last pop, underflow=0.
- Hold cell_ready=0 during a line -> exactly 2 requests acked; mem_request stays 0 until first pop; then fetch resumes.
- 20 line_starts -> char_row 0..19. 21st line fetches from 0x150, char_row=0. After 51×20 lines, addressing restarts at 0x100.
- Set cell_ready=1 before first ack -> underflow=1. With STATS_EN, underflow_count equals the number of empty-FIFO cycles with cell_ready high.
- line_start pulse while busy -> line_overrun=1, no extra requests, next line fetches correct row.
- frame_start during WAIT -> mem_request held to ack, data discarded (no enabled), FIFO empty, next line_start requests base_address with char_row=0.
